yarp_data_mem_responder: RTL

Memory-side responder for the YARP core's load/store data port. It accepts byte, half-word and word requests encoded as `access_byte_t`, holds a word-organised SRAM array, and inserts a configurable number of wait states. It returns right-justified load data or performs lane-masked stores, and flags misaligned or out-of-range accesses. It sits between the core's data-memory unit and the data SRAM, as the target end of that interface.

---
 rtl/yarp_data_mem_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/yarp_data_mem_responder.sv
// Data-port memory responder for the YARP core: a word-organised SRAM behind
// a request/ready handshake, with programmable wait states and access-error flagging.
module yarp_data_mem_responder #(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int WAIT_STATES     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  output logic [31:0] data_rd_data_o,
  output logic        data_ready_o,
  output logic        data_err_o
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {
    BYTE_ACCESS      = 2'd0,
    HALF_WORD_ACCESS = 2'd1,
    RESERVED         = 2'd2,
    WORD_ACCESS      = 2'd3
  } access_byte_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  access_byte_t size_q, size_d;
  logic         wr_q, wr_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         ready_q, ready_d;
  logic         err_q, err_d;

  logic [31:0]   mem [MEM_DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   mem_word;
  logic [4:0]    shamt;
  logic [31:0]   ld_shift;
  logic [31:0]   ld_data;
  logic [31:0]   st_shift;
  logic [3:0]    lane_mask;
  logic [31:0]   bit_mask;
  logic [31:0]   st_word;
  logic          acc_err;
  logic          mem_we;

  // Response datapath works purely from the latched request copy.
  always_comb begin
    idx      = addr_q[AW+1:2];
    mem_word = mem[idx];
    shamt    = {addr_q[1:0], 3'b000};
    ld_shift = mem_word >> shamt;
    st_shift = wdata_q << shamt;
    acc_err  = (size_q == RESERVED)
            || ((size_q == HALF_WORD_ACCESS) && addr_q[0])
            || ((size_q == WORD_ACCESS) && (addr_q[1:0] != 2'b00))
            || (addr_q[31:2] >= 30'(MEM_DEPTH_WORDS));
    case (size_q)
      BYTE_ACCESS: begin
        lane_mask = 4'b0001 << addr_q[1:0];
        ld_data   = {24'b0, ld_shift[7:0]};
      end
      HALF_WORD_ACCESS: begin
        lane_mask = 4'b0011 << {addr_q[1], 1'b0};
        ld_data   = {16'b0, ld_shift[15:0]};
      end
      default: begin
        lane_mask = 4'b1111;
        ld_data   = ld_shift;
      end
    endcase
    bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    st_word  = (mem_word & ~bit_mask) | (st_shift & bit_mask);
    mem_we   = (state_q == S_RESP) && wr_q && !acc_err;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    wr_d    = wr_q;
    rdata_d = '0;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_req_i) begin
          addr_d  = data_addr_i;
          wdata_d = data_wr_data_i;
          size_d  = access_byte_t'(data_byte_en_i);
          wr_d    = data_wr_i;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        // Outputs register at the edge ending RESP, so the strobe lands one cycle later.
        state_d = S_IDLE;
        ready_d = 1'b1;
        err_d   = acc_err;
        rdata_d = (acc_err || wr_q) ? '0 : ld_data;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= BYTE_ACCESS;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= st_word;
  end

  assign data_rd_data_o = rdata_q;
  assign data_ready_o   = ready_q;
  assign data_err_o     = err_q;

endmodule
